lcd_command_exec: RTL



---
 rtl/lcd_command_exec_pkg.sv | 53 +++++
 rtl/lcd_command_exec_if.sv | 8 +
 rtl/lcd_command_exec_bus_writer.sv | 77 +++++++
 rtl/lcd_command_exec.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_command_exec_pkg.sv
// Shared constants, state encodings and helpers for the LCD command executor.
package lcd_cmd_pkg;

  localparam logic [3:0] OP_CLEAR = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_SETAD = 4'h3;
  localparam logic [3:0] OP_WAIT2 = 4'h4;
  localparam logic [3:0] OP_WAIT1 = 4'hF;

  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
  localparam logic [7:0] INIT_ENTRY    = 8'h06;
  localparam logic [7:0] INIT_CLEAR    = 8'h01;

  localparam logic [7:0] DDRAM_SET = 8'h80;
  localparam logic [7:0] CLR_INSTR = 8'h01;

  typedef enum logic [2:0] {
    ST_POWERON,
    ST_INIT,
    ST_INIT_WAIT,
    ST_STROBE,
    ST_SETTLE,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY
  } state_e;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_SETUP,
    BW_EHIGH,
    BW_EWAIT
  } bw_state_e;

  function automatic int unsigned clamp1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_FUNC_SET;
      2'd1:    return INIT_DISP_ON;
      2'd2:    return INIT_ENTRY;
      default: return INIT_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_command_exec_if.sv
// Request/command handshake between the screen command generator and the executor.
interface lcd_command_exec_if;
  logic [11:0] cmd_data;
  logic        cmd_rdy;

  modport master (output cmd_data, input cmd_rdy);
  modport slave  (input cmd_data, output cmd_rdy);
endinterface

// File: rtl/lcd_command_exec_bus_writer.sv
// One HD44780 write: SETUP (1 cycle), EHIGH (E_PULSE_CYC), EWAIT (post_cyc); done on last EWAIT cycle.
module lcd_bus_writer
  import lcd_cmd_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned E_PULSE_CYC = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rs,
  input  logic [7:0]    db,
  input  logic [CW-1:0] post_cyc,
  output logic          done,
  output logic          lcd_rs,
  output logic          lcd_e,
  output logic [7:0]    lcd_db
);

  localparam logic [CW-1:0] E_LAST = CW'(clamp1(E_PULSE_CYC) - 1);

  bw_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] post_q, post_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    post_d  = post_q;
    rs_d    = rs_q;
    db_d    = db_q;
    done    = 1'b0;
    case (state_q)
      BW_IDLE: begin
        if (start) begin
          rs_d    = rs;
          db_d    = db;
          post_d  = post_cyc;
          state_d = BW_SETUP;
        end
      end
      BW_SETUP: state_d = BW_EHIGH;
      BW_EHIGH: if (cnt_q == E_LAST) state_d = BW_EWAIT;
      BW_EWAIT: begin
        if (cnt_q == post_q - 1'b1) begin
          done    = 1'b1;
          state_d = BW_IDLE;
        end
      end
      default: state_d = BW_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
      post_q  <= '0;
      rs_q    <= 1'b0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

  assign lcd_e  = (state_q == BW_EHIGH);
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/lcd_command_exec.sv
// HD44780 16x2 command executor: power-on init, then request/sample/execute loop.
// Optional LCD_COMMAND_EXEC_ERR_EN adds err_op/err_cnt for unknown opcodes.
module lcd_command_exec
  import lcd_cmd_pkg::*;
#(
  parameter int unsigned POWERON_CYC = 750000,
  parameter int unsigned E_PULSE_CYC = 12,
  parameter int unsigned CMD_CYC     = 2000,
  parameter int unsigned CLEAR_CYC   = 82000,
  parameter int unsigned WAIT2_CYC   = 50000000,
  parameter int unsigned SETTLE_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_command_exec_if.slave    cmd,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [7:0]           lcd_db,
  output logic                 lcd_on,
  output logic                 init_done,
  output logic                 busy
`ifdef LCD_COMMAND_EXEC_ERR_EN
  ,
  output logic                 err_op,
  output logic [7:0]           err_cnt
`endif
);

  localparam int unsigned MAXP = max2(max2(max2(POWERON_CYC, E_PULSE_CYC), max2(CMD_CYC, CLEAR_CYC)),
                                      max2(WAIT2_CYC, SETTLE_CYC));
  localparam int unsigned CW = $clog2(MAXP) + 1;
  // STROBE is the first settle cycle, so SETTLE itself holds one cycle less (never below one).
  localparam int unsigned SETTLE_HOLD = (SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 1;

  localparam logic [CW-1:0] PON_LAST    = CW'(clamp1(POWERON_CYC) - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_HOLD - 1);
  localparam logic [CW-1:0] CMD_LAST    = CW'(clamp1(CMD_CYC) - 1);
  localparam logic [CW-1:0] WAIT2_LAST  = CW'(clamp1(WAIT2_CYC) - 1);
  localparam logic [CW-1:0] CMD_POST    = CW'(clamp1(CMD_CYC));
  localparam logic [CW-1:0] CLEAR_POST  = CW'(clamp1(CLEAR_CYC));

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   cmd_q, cmd_d;
  logic          init_done_q, init_done_d;

  logic          bw_start, bw_rs, bw_done;
  logic [7:0]    bw_db;
  logic [CW-1:0] bw_post;

`ifdef LCD_COMMAND_EXEC_ERR_EN
  logic          err_op_q, err_op_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    init_done_d = init_done_q;
    bw_start    = 1'b0;
    bw_rs       = 1'b0;
    bw_db       = '0;
    bw_post     = CMD_POST;
`ifdef LCD_COMMAND_EXEC_ERR_EN
    err_op_d    = err_op_q;
    err_cnt_d   = err_cnt_q;
`endif
    case (state_q)
      ST_POWERON: if (cnt_q == PON_LAST) state_d = ST_INIT;
      ST_INIT: begin
        bw_start = 1'b1;
        bw_db    = init_byte(idx_q);
        bw_post  = (idx_q == 2'd3) ? CLEAR_POST : CMD_POST;
        state_d  = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (bw_done) begin
          if (idx_q == 2'd3) begin
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = ST_STROBE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT;
          end
        end
      end
      ST_STROBE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cmd_d   = cmd.cmd_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cmd_q[11:8])
          OP_CLEAR: begin
            bw_start = 1'b1;
            bw_db    = CLR_INSTR;
            bw_post  = CLEAR_POST;
            state_d  = ST_WRITE;
          end
          OP_WRITE: begin
            bw_start = 1'b1;
            bw_rs    = 1'b1;
            bw_db    = cmd_q[7:0];
            state_d  = ST_WRITE;
          end
          OP_SETAD: begin
            bw_start = 1'b1;
            bw_db    = DDRAM_SET | {1'b0, cmd_q[6:0]};
            state_d  = ST_WRITE;
          end
          OP_WAIT2, OP_WAIT1: state_d = ST_DELAY;
          default: begin
            state_d = ST_DELAY;
`ifdef LCD_COMMAND_EXEC_ERR_EN
            err_op_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
`endif
          end
        endcase
      end
      ST_WRITE: if (bw_done) state_d = ST_STROBE;
      ST_DELAY: begin
        if (cnt_q == ((cmd_q[11:8] == OP_WAIT2) ? WAIT2_LAST : CMD_LAST)) state_d = ST_STROBE;
      end
      default: state_d = ST_POWERON;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_POWERON;
      cnt_q       <= '0;
      idx_q       <= '0;
      cmd_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef LCD_COMMAND_EXEC_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_op_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_op_q  <= err_op_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_op  = err_op_q;
  assign err_cnt = err_cnt_q;
`endif

  lcd_bus_writer #(
    .CW          (CW),
    .E_PULSE_CYC (E_PULSE_CYC)
  ) u_bus_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bw_start),
    .rs       (bw_rs),
    .db       (bw_db),
    .post_cyc (bw_post),
    .done     (bw_done),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .lcd_db   (lcd_db)
  );

  assign cmd.cmd_rdy = (state_q == ST_STROBE);
  assign busy        = (state_q != ST_SETTLE);
  assign init_done   = init_done_q;
  assign lcd_rw      = 1'b0;
  assign lcd_on      = 1'b1;

endmodule
